// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial (a - b - b_in) mod 2^WIDTH, LSB first, with start/busy/done handshake
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             eq
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
   logic [1:0] state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, dif_q, dif_d, top, sh_n;
   logic [CW-1:0] cnt_q, cnt_d;
   logic br_q, br_d, bo_q, bo_d, eq_q, eq_d, di, brn, last, accept, shifting, fin;
   always_comb begin
      di = a_q[0] ^ b_q[0] ^ br_q;
      brn = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      top = '0;
      top[WIDTH-1] = di;
      sh_n = (sh_q >> 1) | top;
      shifting = state_q == SHIFT;
      last = cnt_q == CW'(WIDTH - 1);
      fin = shifting && last;
      accept = start && !shifting;
      state_d = accept ? SHIFT : shifting ? (last ? DONE : SHIFT) : IDLE;
      a_d = accept ? a : shifting ? a_q >> 1 : a_q;
      b_d = accept ? b : shifting ? b_q >> 1 : b_q;
      br_d = accept ? b_in : shifting ? brn : br_q;
      cnt_d = accept ? '0 : shifting ? cnt_q + CW'(1) : cnt_q;
      sh_d = accept ? '0 : shifting ? sh_n : sh_q;
      dif_d = fin ? sh_n : dif_q;
      bo_d = fin ? brn : bo_q;
      eq_d = fin ? sh_n == '0 : eq_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         sh_q <= '0;
         cnt_q <= '0;
         br_q <= 1'b0;
         dif_q <= '0;
         bo_q <= 1'b0;
         eq_q <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         sh_q <= sh_d;
         cnt_q <= cnt_d;
         br_q <= br_d;
         dif_q <= dif_d;
         bo_q <= bo_d;
         eq_q <= eq_d;
      end
   end
   assign busy = state_q == SHIFT;
   assign done = state_q == DONE;
   assign d = dif_q;
   assign b_out = bo_q;
   assign eq = eq_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, hand sequences and random ops against an arithmetic model
module tb_serial_subtractor;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, start8, bi8, busy8, done8, bo8, eq8;
   logic [7:0] a8, b8, d8;
   logic start1, a1, b1, bi1, busy1, done1, d1, bo1, eq1;
   int tests = 0, fails = 0;
   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .b_in(bi8),
      .busy(busy8), .done(done8), .d(d8), .b_out(bo8), .eq(eq8)
   );
   serial_subtractor #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .b_in(bi1),
      .busy(busy1), .done(done1), .d(d1), .b_out(bo1), .eq(eq1)
   );
   typedef struct {
      logic [7:0] a, b;
      logic       bin;
      logic [7:0] d;
      logic       bo, eq;
   } vec_t;
   vec_t tv[6];
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask
   function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
      return {1'b0, x} - {1'b0, y} - 9'(c);
   endfunction
   // inj >= 0 pulses start with scrambled operands that many cycles into SHIFT
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      input bit b2b, input int inj, input string n);
      logic [8:0] r;
      int lat, bc;
      r = ref8(ta, tb_, tc);
      lat = 0;
      bc = 0;
      if (!b2b) @(negedge clk);
      a8 = ta; b8 = tb_; bi8 = tc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      while (!done8 && lat < 40) begin
         bc += int'(busy8);
         start8 = (lat == inj);
         @(negedge clk);
         lat++;
      end
      start8 = 1'b0;
      chk({n, " latency"}, lat, 8);
      chk({n, " busy cycles"}, bc, 8);
      chk({n, " busy at done"}, busy8, 0);
      chk({n, " d"}, d8, r[7:0]);
      chk({n, " b_out"}, bo8, r[8]);
      chk({n, " eq"}, eq8, r[7:0] == 8'h00);
   endtask
   task automatic op1(input logic ta, input logic tb_, input logic tc);
      logic [1:0] r;
      int lat;
      string n;
      r = {1'b0, ta} - {1'b0, tb_} - {1'b0, tc};
      n = $sformatf("w1 %0d-%0d-%0d", ta, tb_, tc);
      lat = 0;
      @(negedge clk);
      a1 = ta; b1 = tb_; bi1 = tc; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      while (!done1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({n, " latency"}, lat, 1);
      chk({n, " d"}, d1, r[0]);
      chk({n, " b_out"}, bo1, r[1]);
      chk({n, " eq"}, eq1, !r[0]);
   endtask
   initial begin
      logic [7:0] hold;
      bit seen;
      tv[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
      tv[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      tv[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1};
      tv[3] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0};
      tv[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
      tv[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("rst busy", busy8, 0);
         chk("rst done", done8, 0);
         chk("rst d", d8, 0);
         chk("rst b_out", bo8, 0);
         chk("rst eq", eq8, 1);
         chk("rst w1 eq", eq1, 1);
         repeat (3) @(negedge clk);
      end
      for (int i = 0; i < 6; i++) begin
         op8(tv[i].a, tv[i].b, tv[i].bin, 1'b0, -1, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d table d", i), d8, tv[i].d);
         chk($sformatf("vec%0d table b_out", i), bo8, tv[i].bo);
         chk($sformatf("vec%0d table eq", i), eq8, tv[i].eq);
      end
      op8(8'h5A, 8'h3C, 1'b0, 1'b0, -1, "hold");
      hold = d8;
      repeat (4) @(negedge clk);
      chk("hold d after idle", d8, hold);
      chk("hold done low", done8, 0);
      op8(8'hC3, 8'h41, 1'b0, 1'b0, 3, "mid start ignored");
      op8(8'h12, 8'h34, 1'b1, 1'b1, -1, "back to back");
      op8(8'h77, 8'h07, 1'b0, 1'b1, -1, "back to back 2");
      op8(8'h5A, 8'h3C, 1'b0, 1'b0, -1, "pre reset");
      @(negedge clk);
      a8 = 8'h5A; b8 = 8'h3C; bi8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", busy8, 0);
      chk("abort d", d8, 0);
      chk("abort b_out", bo8, 0);
      chk("abort eq", eq8, 1);
      seen = 1'b0;
      repeat (12) begin
         seen |= done8;
         @(negedge clk);
      end
      chk("abort no done", seen, 0);
      op8(8'h03, 8'h01, 1'b0, 1'b0, -1, "after abort");
      for (int i = 0; i < 8; i++) op1(i[2], i[1], i[0]);
      for (int i = 0; i < 30; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), -1,
             $sformatf("rand%0d", i));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
